// File: rtl/hdmi_rx_decoder.sv
// hdmi_rx_decoder: receive-side TMDS symbol decoder for one HDMI link.
//   Classifies the three channel symbols of each pixel clock as control,
//   guard band, video or TERC4 island data. It recovers RGB, island nibbles,
//   sync and CTL, tracks preambles and period sequencing, and counts
//   protocol violations.
// Ports:
//   clk_pixel, reset (async, active low)
//   tmds_in[29:0]          channel i symbol on [10i+9:10i]
//   rgb, video_valid       decoded video pixel ({R,G,B})
//   data_island_data, island_valid, packet_start, packet_pixel
//   hsync, vsync, ctl      sync and CTL recovered from control/island periods
//   mode                   0 ctl, 1 video, 2 video guard, 3 island, 4 island guard
//   symbol_error, error_count
// All outputs are registered one edge after the symbol is sampled.

// Per-channel combinational symbol classifier.
module hdmi_rx_lane (
  input  logic [9:0] sym,
  output logic       is_ctl,
  output logic [1:0] ctl_bits,
  output logic       terc_ok,
  output logic [3:0] terc_nib,
  output logic [7:0] vid_byte
);
  logic [7:0] d;

  always_comb begin
    is_ctl   = 1'b1;
    ctl_bits = 2'b00;
    case (sym)
      10'b1101010100: ctl_bits = 2'b00;
      10'b0010101011: ctl_bits = 2'b01;
      10'b0101010100: ctl_bits = 2'b10;
      10'b1010101011: ctl_bits = 2'b11;
      default:        is_ctl   = 1'b0;
    endcase
  end

  // Invalid TERC4 codes decode as zero so downstream never sees garbage.
  always_comb begin
    terc_ok  = 1'b1;
    terc_nib = 4'h0;
    case (sym)
      10'b1010011100: terc_nib = 4'h0;
      10'b1001100011: terc_nib = 4'h1;
      10'b1011100100: terc_nib = 4'h2;
      10'b1011100010: terc_nib = 4'h3;
      10'b0101110001: terc_nib = 4'h4;
      10'b0100011110: terc_nib = 4'h5;
      10'b0110001110: terc_nib = 4'h6;
      10'b0100111100: terc_nib = 4'h7;
      10'b1011001100: terc_nib = 4'h8;
      10'b0100111001: terc_nib = 4'h9;
      10'b0110011100: terc_nib = 4'hA;
      10'b1011000110: terc_nib = 4'hB;
      10'b1010001110: terc_nib = 4'hC;
      10'b1001110001: terc_nib = 4'hD;
      10'b0101100011: terc_nib = 4'hE;
      10'b1011000011: terc_nib = 4'hF;
      default:        terc_ok  = 1'b0;
    endcase
  end

  // 8b/10b video decode: undo the optional inversion, then the XOR/XNOR chain.
  assign d = sym[9] ? ~sym[7:0] : sym[7:0];

  always_comb begin
    vid_byte    = 8'h00;
    vid_byte[0] = d[0];
    for (int i = 1; i < 8; i++)
      vid_byte[i] = sym[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
  end
endmodule

module hdmi_rx_decoder #(
  parameter int unsigned PREAMBLE_MIN = 8,
  parameter int unsigned MAX_PACKETS  = 18
) (
  input  logic        clk_pixel,
  input  logic        reset,
  input  logic [29:0] tmds_in,
  output logic [23:0] rgb,
  output logic        video_valid,
  output logic [11:0] data_island_data,
  output logic        island_valid,
  output logic        packet_start,
  output logic [4:0]  packet_pixel,
  output logic        hsync,
  output logic        vsync,
  output logic [3:0]  ctl,
  output logic [2:0]  mode,
  output logic        symbol_error,
  output logic [15:0] error_count
);
  localparam int unsigned NUM_LANES = 3;
  localparam int unsigned ISL_MAX   = MAX_PACKETS * 32;
  localparam int unsigned CNT_W     = $clog2(ISL_MAX + 1);
  localparam logic [CNT_W-1:0] ISL_MAX_C = CNT_W'(ISL_MAX);
  localparam logic [3:0]  PRE_MIN  = 4'(PREAMBLE_MIN);

  localparam logic [9:0]  VG_BR    = 10'b1011001100;  // video guard ch0/ch2
  localparam logic [9:0]  GB_G     = 10'b0100110011;  // video guard ch1, island guard ch1/ch2

  localparam logic [2:0]  M_CTRL   = 3'd0;
  localparam logic [2:0]  M_VIDEO  = 3'd1;
  localparam logic [2:0]  M_VGUARD = 3'd2;
  localparam logic [2:0]  M_ISLAND = 3'd3;
  localparam logic [2:0]  M_IGUARD = 3'd4;

  typedef enum logic [2:0] {
    ST_CONTROL, ST_VGUARD, ST_VIDEO, ST_DLEAD, ST_ISLAND, ST_DTRAIL
  } state_e;

  logic [NUM_LANES-1:0][9:0] sym;
  logic [NUM_LANES-1:0]      is_ctl;
  logic [NUM_LANES-1:0][1:0] ctl_bits;
  logic [NUM_LANES-1:0]      terc_ok;
  logic [NUM_LANES-1:0][3:0] terc_nib;
  logic [NUM_LANES-1:0][7:0] vid_byte;

  assign sym = tmds_in;

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    hdmi_rx_lane u_lane (
      .sym      (sym[l]),
      .is_ctl   (is_ctl[l]),
      .ctl_bits (ctl_bits[l]),
      .terc_ok  (terc_ok[l]),
      .terc_nib (terc_nib[l]),
      .vid_byte (vid_byte[l])
    );
  end

  logic vguard, iguard;
  assign vguard = (sym[0] == VG_BR) && (sym[1] == GB_G) && (sym[2] == VG_BR);
  assign iguard = (sym[1] == GB_G) && (sym[2] == GB_G);

  state_e           state_q, state_d;
  logic [3:0]       vpre_q, vpre_d, ipre_q, ipre_d;
  logic             vg2_q, vg2_d;      // second video guard already seen
  logic [4:0]       pp_q, pp_d;        // index the next island symbol gets
  logic [CNT_W-1:0] scnt_q, scnt_d;    // island symbols since the leading guard
  logic [23:0]      rgb_q, rgb_d;
  logic             vvld_q, vvld_d;
  logic [11:0]      did_q, did_d;
  logic             ivld_q, ivld_d;
  logic             pstart_q, pstart_d;
  logic [4:0]       ppix_q, ppix_d;
  logic             hs_q, hs_d, vs_q, vs_d;
  logic [3:0]       ctl_q, ctl_d;
  logic [2:0]       mode_q, mode_d;
  logic             err_q, err_d;
  logic [15:0]      ecnt_q, ecnt_d;

  logic             do_ctl, do_vid;
  logic [3:0]       tok_ctl;

  assign tok_ctl = {ctl_bits[2], ctl_bits[1]};

  always_comb begin
    state_d  = state_q;
    vpre_d   = vpre_q;
    ipre_d   = ipre_q;
    vg2_d    = vg2_q;
    pp_d     = pp_q;
    scnt_d   = scnt_q;
    rgb_d    = rgb_q;
    vvld_d   = 1'b0;
    did_d    = did_q;
    ivld_d   = 1'b0;
    pstart_d = 1'b0;
    ppix_d   = ppix_q;
    hs_d     = hs_q;
    vs_d     = vs_q;
    ctl_d    = ctl_q;
    mode_d   = M_CTRL;
    err_d    = 1'b0;
    do_ctl   = 1'b0;
    do_vid   = 1'b0;

    case (state_q)
      ST_CONTROL: begin
        if (vguard) begin
          // A guard always breaks the preamble run, accepted or not.
          vpre_d = 4'd0;
          ipre_d = 4'd0;
          if (vpre_q >= PRE_MIN) begin
            state_d = ST_VGUARD;
            vg2_d   = 1'b0;
            mode_d  = M_VGUARD;
          end else begin
            err_d   = 1'b1;
          end
        end else if (iguard) begin
          vpre_d = 4'd0;
          ipre_d = 4'd0;
          if (ipre_q >= PRE_MIN) begin
            state_d = ST_DLEAD;
            mode_d  = M_IGUARD;
            hs_d    = terc_nib[0][0];
            vs_d    = terc_nib[0][1];
          end else begin
            err_d   = 1'b1;
          end
        end else begin
          do_ctl = 1'b1;
        end
      end

      ST_VGUARD: begin
        if (!vg2_q) begin
          if (vguard) begin
            vg2_d  = 1'b1;
            mode_d = M_VGUARD;
          end else begin
            err_d   = 1'b1;
            state_d = ST_CONTROL;
          end
        end else if (vguard || is_ctl[0]) begin
          err_d   = 1'b1;
          state_d = ST_CONTROL;
        end else begin
          state_d = ST_VIDEO;
          do_vid  = 1'b1;
        end
      end

      ST_VIDEO: begin
        if (is_ctl[0]) begin
          state_d = ST_CONTROL;
          do_ctl  = 1'b1;
        end else begin
          do_vid  = 1'b1;
        end
      end

      ST_DLEAD: begin
        mode_d = M_IGUARD;
        hs_d   = terc_nib[0][0];
        vs_d   = terc_nib[0][1];
        if (iguard) begin
          state_d = ST_ISLAND;
          pp_d    = 5'd0;
          scnt_d  = '0;
        end else begin
          err_d   = 1'b1;
          state_d = ST_CONTROL;
        end
      end

      ST_ISLAND: begin
        if (iguard) begin
          // Trailing guard must land on a packet boundary.
          state_d = ST_DTRAIL;
          mode_d  = M_IGUARD;
          err_d   = (pp_q != 5'd0);
        end else if (scnt_q == ISL_MAX_C) begin
          err_d   = 1'b1;
          state_d = ST_CONTROL;
        end else begin
          mode_d   = M_ISLAND;
          ivld_d   = 1'b1;
          did_d    = {terc_nib[2], terc_nib[1], terc_nib[0]};
          err_d    = ~&terc_ok;
          pstart_d = (pp_q == 5'd0);
          ppix_d   = pp_q;
          pp_d     = pp_q + 5'd1;
          scnt_d   = scnt_q + CNT_W'(1);
          hs_d     = terc_nib[0][0];
          vs_d     = terc_nib[0][1];
        end
      end

      ST_DTRAIL: begin
        mode_d  = M_IGUARD;
        state_d = ST_CONTROL;
        err_d   = ~iguard;
      end

      default: begin
        state_d = ST_CONTROL;
      end
    endcase

    if (do_vid) begin
      mode_d = M_VIDEO;
      vvld_d = 1'b1;
      rgb_d  = {vid_byte[2], vid_byte[1], vid_byte[0]};
    end

    // Control-period symbol: all channels must carry tokens.
    if (do_ctl) begin
      if (&is_ctl) begin
        hs_d  = ctl_bits[0][0];
        vs_d  = ctl_bits[0][1];
        ctl_d = tok_ctl;
        if (tok_ctl == 4'b0001) begin
          vpre_d = (vpre_q == 4'd15) ? vpre_q : vpre_q + 4'd1;
          ipre_d = 4'd0;
        end else if (tok_ctl == 4'b0101) begin
          ipre_d = (ipre_q == 4'd15) ? ipre_q : ipre_q + 4'd1;
          vpre_d = 4'd0;
        end else begin
          vpre_d = 4'd0;
          ipre_d = 4'd0;
        end
      end else begin
        err_d  = 1'b1;
        vpre_d = 4'd0;
        ipre_d = 4'd0;
      end
    end

    ecnt_d = (err_d && (ecnt_q != 16'hFFFF)) ? ecnt_q + 16'd1 : ecnt_q;
  end

  always_ff @(posedge clk_pixel or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_CONTROL;
      vpre_q   <= 4'd0;
      ipre_q   <= 4'd0;
      vg2_q    <= 1'b0;
      pp_q     <= 5'd0;
      scnt_q   <= '0;
      rgb_q    <= 24'h0;
      vvld_q   <= 1'b0;
      did_q    <= 12'h0;
      ivld_q   <= 1'b0;
      pstart_q <= 1'b0;
      ppix_q   <= 5'd0;
      hs_q     <= 1'b0;
      vs_q     <= 1'b0;
      ctl_q    <= 4'h0;
      mode_q   <= M_CTRL;
      err_q    <= 1'b0;
      ecnt_q   <= 16'h0;
    end else begin
      state_q  <= state_d;
      vpre_q   <= vpre_d;
      ipre_q   <= ipre_d;
      vg2_q    <= vg2_d;
      pp_q     <= pp_d;
      scnt_q   <= scnt_d;
      rgb_q    <= rgb_d;
      vvld_q   <= vvld_d;
      did_q    <= did_d;
      ivld_q   <= ivld_d;
      pstart_q <= pstart_d;
      ppix_q   <= ppix_d;
      hs_q     <= hs_d;
      vs_q     <= vs_d;
      ctl_q    <= ctl_d;
      mode_q   <= mode_d;
      err_q    <= err_d;
      ecnt_q   <= ecnt_d;
    end
  end

  assign rgb              = rgb_q;
  assign video_valid      = vvld_q;
  assign data_island_data = did_q;
  assign island_valid     = ivld_q;
  assign packet_start     = pstart_q;
  assign packet_pixel     = ppix_q;
  assign hsync            = hs_q;
  assign vsync            = vs_q;
  assign ctl              = ctl_q;
  assign mode             = mode_q;
  assign symbol_error     = err_q;
  assign error_count      = ecnt_q;
endmodule

// File: tb/tb_hdmi_rx_decoder.sv
// tb_hdmi_rx_decoder: randomized self-checking bench for hdmi_rx_decoder.
// Stimulus is built as whole periods (control runs, video bursts, islands);
// expected outputs come from what each period was generated from (source
// pixels encoded with an 8b/10b encoder, source nibbles mapped to TERC4).
module tb_hdmi_rx_decoder;
  localparam int ISL_MAX = 64;  // MAX_PACKETS = 2

  logic        clk_pixel = 1'b0;
  logic        reset;
  logic [29:0] tmds_in;
  logic [23:0] rgb;
  logic        video_valid;
  logic [11:0] data_island_data;
  logic        island_valid;
  logic        packet_start;
  logic [4:0]  packet_pixel;
  logic        hsync, vsync;
  logic [3:0]  ctl;
  logic [2:0]  mode;
  logic        symbol_error;
  logic [15:0] error_count;

  hdmi_rx_decoder #(.PREAMBLE_MIN(8), .MAX_PACKETS(2)) dut (
    .clk_pixel        (clk_pixel),
    .reset            (reset),
    .tmds_in          (tmds_in),
    .rgb              (rgb),
    .video_valid      (video_valid),
    .data_island_data (data_island_data),
    .island_valid     (island_valid),
    .packet_start     (packet_start),
    .packet_pixel     (packet_pixel),
    .hsync            (hsync),
    .vsync            (vsync),
    .ctl              (ctl),
    .mode             (mode),
    .symbol_error     (symbol_error),
    .error_count      (error_count)
  );

  always #5 clk_pixel = ~clk_pixel;

  int total = 0;
  int bad   = 0;

  // Expected held outputs.
  logic [23:0] exp_rgb;
  logic [11:0] exp_did;
  logic [4:0]  exp_pp;
  logic        exp_hs, exp_vs;
  logic [3:0]  exp_ctl;
  logic [15:0] exp_ecnt;
  // Current run of identical control values.
  logic [3:0]  run_ctl;
  int          run_len;

  localparam logic [9:0] VGB = 10'b1011001100;
  localparam logic [9:0] GBG = 10'b0100110011;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [9:0] tok(input logic [1:0] c);
    case (c)
      2'd0: return 10'b1101010100;
      2'd1: return 10'b0010101011;
      2'd2: return 10'b0101010100;
      default: return 10'b1010101011;
    endcase
  endfunction

  function automatic logic [9:0] terc(input logic [3:0] n);
    logic [9:0] t [16];
    t = '{10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
          10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
          10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
          10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011};
    return t[n];
  endfunction

  // Transmit-side encode: XOR or XNOR chain, optional inversion.
  function automatic logic [9:0] tmds_enc(input logic [7:0] p, input logic use_xor, input logic inv);
    logic [7:0] qm;
    qm[0] = p[0];
    for (int i = 1; i < 8; i++) qm[i] = use_xor ? (qm[i-1] ^ p[i]) : ~(qm[i-1] ^ p[i]);
    return {inv, use_xor, inv ? ~qm : qm};
  endfunction

  function automatic logic reserved(input logic [9:0] s);
    return (s == tok(2'd0)) || (s == tok(2'd1)) || (s == tok(2'd2)) ||
           (s == tok(2'd3)) || (s == VGB) || (s == GBG);
  endfunction

  task automatic gen_px(output logic [9:0] s, output logic [7:0] v);
    s = 10'b0100000000;
    v = 8'h00;
    for (int t = 0; t < 16; t++) begin
      logic [7:0] p;
      logic [9:0] c;
      p = 8'($urandom);
      c = tmds_enc(p, 1'($urandom), 1'($urandom));
      if (!reserved(c)) begin
        s = c;
        v = p;
        break;
      end
    end
  endtask

  // Entered at a negedge; drives one symbol, checks after the edge, returns at a negedge.
  task automatic send(input logic [29:0] s, input logic [2:0] md, input logic vv,
                      input logic iv, input logic ps, input logic er);
    tmds_in = s;
    @(posedge clk_pixel);
    #1;
    if (er) exp_ecnt++;
    chk("mode",   32'(mode),             32'(md));
    chk("vvalid", 32'(video_valid),      32'(vv));
    chk("ivalid", 32'(island_valid),     32'(iv));
    chk("pstart", 32'(packet_start),     32'(ps));
    chk("err",    32'(symbol_error),     32'(er));
    chk("ecnt",   32'(error_count),      32'(exp_ecnt));
    chk("hsync",  32'(hsync),            32'(exp_hs));
    chk("vsync",  32'(vsync),            32'(exp_vs));
    chk("ctl",    32'(ctl),              32'(exp_ctl));
    chk("rgb",    32'(rgb),              32'(exp_rgb));
    chk("did",    32'(data_island_data), 32'(exp_did));
    chk("ppix",   32'(packet_pixel),     32'(exp_pp));
    @(negedge clk_pixel);
  endtask

  function automatic logic [29:0] ctl_sym(input logic [3:0] c, input logic hs, input logic vs);
    return {tok(c[3:2]), tok(c[1:0]), tok({vs, hs})};
  endfunction

  task automatic ctl_send(input logic [3:0] c);
    logic hs, vs;
    hs = 1'($urandom);
    vs = 1'($urandom);
    exp_hs  = hs;
    exp_vs  = vs;
    exp_ctl = c;
    if (run_len > 0 && c == run_ctl) run_len++;
    else begin
      run_ctl = c;
      run_len = 1;
    end
    send(ctl_sym(c, hs, vs), 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic model_reset();
    exp_rgb = '0; exp_did = '0; exp_pp = '0; exp_hs = 0; exp_vs = 0;
    exp_ctl = '0; exp_ecnt = '0; run_ctl = '0; run_len = 0;
  endtask

  // nguard = 2 normally; 3 plants an extra guard.
  task automatic video_burst(input int npx, input int nguard);
    logic ok;
    logic [9:0] s2, s1, s0;
    logic [7:0] v2, v1, v0;
    ok = (run_ctl == 4'b0001) && (run_len >= 8);
    run_len = 0;
    if (!ok) begin
      send({VGB, GBG, VGB}, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
      return;
    end
    send({VGB, GBG, VGB}, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    send({VGB, GBG, VGB}, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    if (nguard > 2) begin
      send({VGB, GBG, VGB}, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
      return;
    end
    for (int i = 0; i < npx; i++) begin
      gen_px(s0, v0);
      gen_px(s1, v1);
      gen_px(s2, v2);
      exp_rgb = {v2, v1, v0};
      send({s2, s1, s0}, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    end
  endtask

  // tmode: 0 trailing guards, 1 run past the limit, 2 stop after data.
  task automatic island_burst(input int n, input int tmode, input bit allow_bad);
    logic ok, hs, vs, er;
    logic [3:0] nb [3];
    logic [9:0] sc [3];
    ok = (run_ctl == 4'b0101) && (run_len >= 8);
    run_len = 0;
    if (!ok) begin
      send({GBG, GBG, terc(4'hC)}, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
      return;
    end
    for (int g = 0; g < 2; g++) begin
      hs = 1'($urandom);
      vs = 1'($urandom);
      exp_hs = hs;
      exp_vs = vs;
      send({GBG, GBG, terc({2'b11, vs, hs})}, 3'd4, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    for (int i = 0; i < n; i++) begin
      er = 1'b0;
      for (int c = 0; c < 3; c++) begin
        nb[c] = 4'($urandom);
        sc[c] = terc(nb[c]);
      end
      if (allow_bad && $urandom_range(0, 15) == 0) begin
        int c;
        c = $urandom_range(0, 2);
        sc[c] = tok(2'd0);
        nb[c] = 4'h0;
        er = 1'b1;
      end
      exp_did = {nb[2], nb[1], nb[0]};
      exp_pp  = 5'(i % 32);
      exp_hs  = nb[0][0];
      exp_vs  = nb[0][1];
      send({sc[2], sc[1], sc[0]}, 3'd3, 1'b0, 1'b1, (i % 32) == 0, er);
    end
    if (tmode == 0) begin
      send({GBG, GBG, terc(4'hF)}, 3'd4, 1'b0, 1'b0, 1'b0, (n % 32) != 0);
      send({GBG, GBG, terc(4'hF)}, 3'd4, 1'b0, 1'b0, 1'b0, 1'b0);
    end else if (tmode == 1) begin
      send({terc(4'h3), terc(4'h2), terc(4'h1)}, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    end
  endtask

  task automatic preamble(input logic [3:0] c, input int n);
    for (int i = 0; i < n; i++) ctl_send(c);
  endtask

  task automatic async_reset_check(input string tag);
    #2 reset = 1'b0;
    #1;
    chk({tag, "_rgb"},    32'(rgb),          32'h0);
    chk({tag, "_mode"},   32'(mode),         32'h0);
    chk({tag, "_vvalid"}, 32'(video_valid),  32'h0);
    chk({tag, "_ivalid"}, 32'(island_valid), 32'h0);
    chk({tag, "_ecnt"},   32'(error_count),  32'h0);
    tmds_in = ctl_sym(4'h0, 1'b0, 1'b0);
    repeat (2) @(negedge clk_pixel);
    reset = 1'b1;
    model_reset();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    model_reset();
    reset   = 1'b0;
    tmds_in = ctl_sym(4'h0, 1'b0, 1'b0);
    repeat (3) @(negedge clk_pixel);
    chk("rst_rgb",   32'(rgb),              32'h0);
    chk("rst_mode",  32'(mode),             32'h0);
    chk("rst_did",   32'(data_island_data), 32'h0);
    chk("rst_err",   32'(symbol_error),     32'h0);
    chk("rst_ecnt",  32'(error_count),      32'h0);
    chk("rst_ivld",  32'(island_valid),     32'h0);
    reset = 1'b1;

    // Short preamble: guard rejected, single error.
    preamble(4'b0001, 6);
    video_burst(4, 2);
    chk("short_pre_ecnt", 32'(error_count), 32'h1);

    // Minimal qualifying preamble, then video; fixed first pixel.
    preamble(4'b0001, 8);
    run_len = 0;
    send({VGB, GBG, VGB}, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    send({VGB, GBG, VGB}, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    exp_rgb = 24'h0;
    send({10'b0100000000, 10'b0100000000, 10'b0100000000}, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    preamble(4'b0000, 3);

    // Seven preamble cycles is one short.
    preamble(4'b0001, 7);
    video_burst(3, 2);
    preamble(4'b0000, 2);

    // Third video guard.
    preamble(4'b0001, 9);
    video_burst(0, 3);
    preamble(4'b0010, 2);

    // Two full packets, clean trailing guard.
    preamble(4'b0101, 8);
    island_burst(64, 0, 0);
    preamble(4'b0000, 2);

    // Trailing guard mid-packet.
    preamble(4'b0101, 8);
    island_burst(17, 0, 0);
    preamble(4'b0000, 2);

    // No trailing guard: abort after MAX_PACKETS*32 symbols.
    preamble(4'b0101, 10);
    island_burst(ISL_MAX, 1, 0);
    preamble(4'b0000, 2);

    // Reset during video, then a guard with no fresh preamble.
    preamble(4'b0001, 8);
    video_burst(5, 2);
    async_reset_check("rst_video");
    video_burst(2, 2);
    preamble(4'b0000, 2);

    // Reset mid-island.
    preamble(4'b0101, 8);
    island_burst(10, 2, 0);
    async_reset_check("rst_island");

    // Randomized frames.
    for (int it = 0; it < 30; it++) begin
      int kind, plen, r, n;
      repeat ($urandom_range(1, 3)) ctl_send(4'($urandom));
      kind = $urandom_range(0, 1);
      plen = $urandom_range(6, 11);
      preamble(kind ? 4'b0101 : 4'b0001, plen);
      if (kind == 0) begin
        video_burst($urandom_range(1, 20), 2);
      end else begin
        r = $urandom_range(0, 2);
        n = (r == 0) ? 32 : (r == 1) ? 64 : $urandom_range(1, 63);
        island_burst(n, 0, 1);
      end
      repeat ($urandom_range(1, 2)) ctl_send(4'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/hdmi_rx_decoder.md
# hdmi_rx_decoder

Receive-side TMDS symbol decoder for the HDMI sink path, mirroring the transmitter's channel encoders and period sequencing. Takes three word-aligned 10-bit TMDS symbols per pixel clock from the deserializer PHY and classifies each symbol as control, preamble, guard band, video or data island. It recovers 24-bit RGB, 12-bit TERC4 island data, HSYNC/VSYNC and CTL[3:0], and reports protocol violations. Its outputs feed the downstream packet disassembler and video timing recovery.

## Interface
- PREAMBLE_MIN, 8: consecutive identical preamble cycles required before a guard band is accepted.
- MAX_PACKETS, 18: maximum packets per data island; the island aborts at MAX_PACKETS*32 symbols.
- clk_pixel  in  1  pixel clock; one symbol per channel per cycle.
- reset  in  1  asynchronous, active-low (0 = reset).
- tmds_in  in  30  channel i symbol on [10i+9:10i]; bit 0 is first on the wire.
- rgb  out  24  decoded video: [7:0]=ch0 (B), [15:8]=ch1 (G), [23:16]=ch2 (R).
- video_valid  out  1  rgb holds a video-period pixel.
- data_island_data  out  12  TERC4 nibbles: [3:0]=ch0, [7:4]=ch1, [11:8]=ch2.
- island_valid  out  1  data_island_data holds packet content.
- packet_start  out  1  pulses on the first symbol of each 32-symbol packet.
- packet_pixel  out  5  symbol index within the current packet.
- hsync, vsync  out  1 each  recovered sync.
- ctl  out  4  {ch2 c1, ch2 c0, ch1 c1, ch1 c0}, latched from control periods.
- mode  out  3  0 control, 1 video, 2 video guard, 3 island, 4 island guard.
- symbol_error  out  1  one-cycle pulse per violation.
- error_count  out  16  saturating violation count.

## Operation
- Control tokens (c1c0): 00=1101010100, 01=0010101011, 10=0101010100, 11=1010101011.
- Video guard band: ch0/ch2 = 1011001100, ch1 = 0100110011. Island guard band: ch1/ch2 = 0100110011; ch0 carries TERC4 {1,1,vsync,hsync}.
- TERC4 codes 0..F: 1010011100, 1001100011, 1011100100, 1011100010, 0101110001, 0100011110, 0110001110, 0100111100, 1011001100, 0100111001, 0110011100, 1011000110, 1010001110, 1001110001, 0101100011, 1011000011.
- Video decode: d = q[9] ? ~q[7:0] : q[7:0]. out[0] = d[0]. For i = 1..7, out[i] = d[i]^d[i-1] when q[8]=1; otherwise out[i] = ~(d[i]^d[i-1]).
- States: CONTROL, VGUARD, VIDEO, DLEAD, ISLAND, DTRAIL.
- Preamble counters:
  - In CONTROL, consecutive cycles with ctl = 0001 increment the video preamble count; ctl = 0101 increments the island preamble count.
  - Both counters saturate at 15. Any other ctl value clears both.
- CONTROL -> VGUARD: all three channels show the video guard band and the video preamble count ≥ PREAMBLE_MIN.
- CONTROL -> DLEAD: ch1 and ch2 show the island guard band and the island preamble count ≥ PREAMBLE_MIN.
- A guard band seen without a qualifying preamble: symbol_error pulses and the state stays CONTROL.
- VGUARD:
  - Exactly 2 guard symbols, then VIDEO.
  - A third guard symbol or a control token: error, then CONTROL.
- VIDEO: exits to CONTROL on a control token on ch0. A symbol that is neither a control token nor a valid video symbol does not occur by construction; no check is made.
- DLEAD:
  - Exactly 2 guard symbols, then ISLAND with packet_pixel = 0.
  - During DLEAD, ch0 TERC4 bits [1:0] update hsync/vsync.
- ISLAND:
  - packet_pixel increments and wraps at 31; packet_start pulses when it is 0.
  - All three channels must be valid TERC4 codes; an invalid code pulses error and decodes as 0.
  - hsync/vsync follow ch0 data[1:0].
  - ch1/ch2 island guard band -> DTRAIL. If packet_pixel ≠ 0 at that point, error.
  - On reaching MAX_PACKETS*32 symbols without a guard: error, then CONTROL.
- DTRAIL: 2 guard symbols, then CONTROL.
- CONTROL-state checks: any non-control symbol that is not an accepted guard pulses error. Tokens update hsync/vsync from ch0 and ctl from ch1/ch2.
- rgb, ctl and data_island_data hold their values outside their own periods.

## Timing
- Latency: tmds_in sampled at edge n -> all outputs registered at edge n+1.
- mode for a symbol equals the state the symbol is classified into.
- error_count increments on the same edge as symbol_error and saturates at 16'hFFFF.
- Reset: all outputs 0, state CONTROL, preamble counters 0. Reset asserted mid-island drops island_valid within the assertion, asynchronously.
- Simultaneous preamble-end and guard band: the count reached on the previous cycle qualifies.

## Test plan
- 8 cycles of ctl=0001, then 2 video guards, then ch0 symbol 0100000000 (q9=0, q8=1, d=00000000) -> mode 2, 2, then 1; rgb[7:0]=8'h00; video_valid=1 one cycle after input.
- 8 cycles of ctl=0101, 2 island guards, 64 TERC4 symbols, 2 guards -> packet_start at symbols 0 and 32; island_valid for 64 cycles; symbol_error never asserts.
- Only 6 preamble cycles before the video guard -> symbol_error=1, mode stays 0, error_count=1.
- Island trailing guard at packet_pixel=17 -> symbol_error=1, state DTRAIL, then CONTROL.
- Island with no trailing guard, MAX_PACKETS=2 -> error at symbol 64, then CONTROL.
- Pull reset low during VIDEO -> rgb=0 and mode=0 immediately; after release, decoding resumes only after a fresh preamble.
